// File: rtl/serial_subtractor_pkg.sv
// Shared definitions for the bit-serial subtractor: state encoding and width limits.
// No logic; latency and backpressure are properties of the users.
// Imported by the top level.
package serial_subtractor_pkg;

    localparam int WIDTH_MIN = 2;
    localparam int WIDTH_MAX = 32;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    function automatic bit width_ok(input int w);
        return (w >= WIDTH_MIN) && (w <= WIDTH_MAX);
    endfunction

endpackage

// File: rtl/full_subtractor_bit.sv
// One-bit full subtractor: d = x - y - bin, from two half subtractors and an OR.
// Zero latency.
// No flow control.
module full_subtractor_bit (
    input  logic x,
    input  logic y,
    input  logic bin,
    output logic d,
    output logic bout
);

    logic d1;
    logic b1;
    logic b2;

    half_subtractor u_hs0 (
        .x  (x),
        .y  (y),
        .d  (d1),
        .bo (b1)
    );

    half_subtractor u_hs1 (
        .x  (d1),
        .y  (bin),
        .d  (d),
        .bo (b2)
    );

    assign bout = b1 | b2;

endmodule

// File: rtl/half_subtractor.sv
// Combinational half subtractor: d = x - y, bo set when y > x.
// Zero latency.
// No flow control.
module half_subtractor (
    input  logic x,
    input  logic y,
    output logic d,
    output logic bo
);

    assign d  = x ^ y;
    assign bo = ~x & y;

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial unsigned subtractor a - b, one bit per clock, LSB first.
// Latency WIDTH+1 cycles from accepted start to the one-cycle done pulse.
// start is ignored while busy; diff/borrow hold until the next done.
module serial_subtractor
    import serial_subtractor_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             borrow
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

    generate
        if (!width_ok(WIDTH)) begin : g_bad_width
            $error("serial_subtractor: WIDTH out of range 2..32");
        end
    endgenerate

    state_t          state;
    state_t          state_nxt;
    logic [WIDTH-1:0] sa;
    logic [WIDTH-1:0] sb;
    logic [WIDTH-1:0] sr;
    logic             bq;
    logic [CW-1:0]    cnt;
    logic             accept;
    logic             last;
    logic             d;
    logic             bout;

    full_subtractor_bit u_fsb (
        .x    (sa[0]),
        .y    (sb[0]),
        .bin  (bq),
        .d    (d),
        .bout (bout)
    );

    assign last = (cnt == CNT_LAST);

    always_comb begin
        state_nxt = state;
        accept    = 1'b0;
        case (state)
            S_IDLE, S_DONE: begin
                if (start) begin
                    accept    = 1'b1;
                    state_nxt = S_RUN;
                end else begin
                    state_nxt = S_IDLE;
                end
            end
            S_RUN: begin
                if (last) begin
                    state_nxt = S_DONE;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    assign busy = (state == S_RUN);
    assign done = (state == S_DONE);

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= S_IDLE;
            sa     <= '0;
            sb     <= '0;
            sr     <= '0;
            bq     <= 1'b0;
            cnt    <= '0;
            diff   <= '0;
            borrow <= 1'b0;
        end else begin
            state <= state_nxt;
            if (accept) begin
                sa  <= a;
                sb  <= b;
                bq  <= 1'b0;
                cnt <= '0;
            end else if (state == S_RUN) begin
                sa <= {1'b0, sa[WIDTH-1:1]};
                sb <= {1'b0, sb[WIDTH-1:1]};
                sr <= {d, sr[WIDTH-1:1]};
                bq <= bout;
                // The final step publishes the result directly; cnt parks at 0 instead of wrapping.
                if (last) begin
                    cnt    <= '0;
                    diff   <= {d, sr[WIDTH-1:1]};
                    borrow <= bout;
                end else begin
                    cnt <= cnt + 1'b1;
                end
            end
        end
    end

endmodule
